// File: rtl/mem_stage_if.sv
// mem_stage_if: execute, write-back, decode and data-SRAM buses of the memory stage
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 108,
  parameter int MS_TO_WS_BUS_WD = 71
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [37:0]                ms_to_ds_bus;
  logic                       data_sram_req;
  logic                       data_sram_wr;
  logic [1:0]                 data_sram_size;
  logic [3:0]                 data_sram_wstrb;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;
  logic                       data_sram_addr_ok;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata
  );
  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage driving an SRAM-like req/addr_ok/data_ok data port
module mem_stage (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave m
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
  logic         r_valid;
  logic [107:0] r_bus;
  logic [1:0]   r_state;
  logic [31:0]  r_rdata;
  logic         w_uns, w_we, w_en, w_no_dest, w_gr_we;
  logic [1:0]   w_size;
  logic [4:0]   w_dest;
  logic [31:0]  w_sd, w_alu, w_pc;
  logic         w_dok, w_ready_go, w_allowin, w_accept, w_leave;
  logic [31:0]  w_raw, w_ld, w_result;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [3:0]   w_wstrb;
  logic [31:0]  w_wdata;
  assign {w_uns, w_size, w_we, w_en, w_no_dest, w_gr_we, w_dest, w_sd, w_alu, w_pc} = r_bus;
  assign w_dok      = r_state == S_WAIT && m.data_sram_data_ok;
  assign w_ready_go = !w_en || w_dok || r_state == S_DONE;
  assign w_allowin  = !r_valid || (w_ready_go && m.ws_allowin);
  assign w_accept   = m.es_to_ms_valid && w_allowin;
  assign w_leave    = r_valid && w_ready_go && m.ws_allowin;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      if (w_allowin) r_valid <= m.es_to_ms_valid;
      if (w_accept) r_bus <= m.es_to_ms_bus;
      if (w_dok) r_rdata <= m.data_sram_rdata;
      if (w_accept) r_state <= m.es_to_ms_bus[103] ? S_REQ : S_IDLE;
      else if (w_leave) r_state <= S_IDLE;
      else if (r_state == S_REQ && m.data_sram_addr_ok) r_state <= S_WAIT;
      else if (w_dok) r_state <= S_DONE;
    end
  end
  // in DONE the bus may carry unrelated data, so extract from the captured copy
  assign w_raw    = r_state == S_DONE ? r_rdata : m.data_sram_rdata;
  assign w_byte   = w_raw[{w_alu[1:0], 3'b000} +: 8];
  assign w_half   = w_alu[1] ? w_raw[31:16] : w_raw[15:0];
  assign w_ld     = w_size == 2'd0 ? {{24{~w_uns & w_byte[7]}}, w_byte} :
                    w_size == 2'd1 ? {{16{~w_uns & w_half[15]}}, w_half} : w_raw;
  assign w_result = (w_en && !w_we) ? w_ld : w_alu;
  assign w_wstrb  = !w_we ? 4'b0000 :
                    w_size == 2'd0 ? 4'b0001 << w_alu[1:0] :
                    w_size == 2'd1 ? (w_alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata  = w_size == 2'd0 ? {4{w_sd[7:0]}} : w_size == 2'd1 ? {2{w_sd[15:0]}} : w_sd;
  assign m.ms_allowin      = w_allowin;
  assign m.ms_to_ws_valid  = r_valid && w_ready_go;
  assign m.ms_to_ws_bus    = {w_no_dest, w_gr_we, w_dest, w_result, w_pc};
  assign m.ms_to_ds_bus    = {r_valid && w_en && !w_we && !w_ready_go,
                              (r_valid && w_gr_we) ? w_dest : 5'd0, w_result};
  assign m.data_sram_req   = r_state == S_REQ;
  assign m.data_sram_wr    = w_we;
  assign m.data_sram_size  = w_size;
  assign m.data_sram_wstrb = w_wstrb;
  assign m.data_sram_addr  = w_alu;
  assign m.data_sram_wdata = w_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a latency-programmable SRAM responder
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .resetn(resetn), .m(bus));
  int checks = 0, passed = 0;
  logic [70:0] exp_q[$];
  logic [70:0] mon_exp;
  int a_dly = 0, d_dly = 0, n_req = 0, ca = 0, cd = 0;
  logic pend = 1'b0, use_fn = 1'b0, manual = 1'b0, man_dok = 1'b0;
  logic [31:0] rd_val = '0, lat_addr = '0, s_addr;
  logic s_req, s_aok, s_dok;

  initial forever #5 clk = ~clk;

  function automatic logic [107:0] mk(input logic uns, input logic [1:0] sz, input logic we, input logic en,
                                      input logic [4:0] dest, input logic [31:0] sd, input logic [31:0] alu,
                                      input logic [31:0] pc);
    return {uns, sz, we, en, 1'b0, ~we, dest, sd, alu, pc};
  endfunction

  function automatic logic [70:0] exp_wb(input logic gr_we, input logic [4:0] dest, input logic [31:0] res,
                                         input logic [31:0] pc);
    return {1'b0, gr_we, dest, res, pc};
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // SRAM model: addr_ok after a_dly req cycles, data_ok d_dly cycles later, garbage rdata otherwise
  initial forever begin
    @(negedge clk);
    s_req = bus.data_sram_req; s_aok = bus.data_sram_addr_ok; s_dok = bus.data_sram_data_ok; s_addr = bus.data_sram_addr;
    @(posedge clk); #1;
    if (!resetn) begin
      pend = 1'b0; ca = 0; cd = 0;
    end else begin
      if (pend && s_dok) begin pend = 1'b0; cd = 0; end
      else if (pend) cd++;
      if (s_req && s_aok) begin pend = 1'b1; cd = 0; ca = 0; lat_addr = s_addr; n_req++; end
      else if (s_req) ca++;
      else ca = 0;
    end
    bus.data_sram_addr_ok = manual ? 1'b0 : (bus.data_sram_req && !pend && ca >= a_dly);
    bus.data_sram_data_ok = manual ? man_dok : (pend && cd >= d_dly);
    bus.data_sram_rdata = (bus.data_sram_data_ok && !manual) ? (use_fn ? mem_fn(lat_addr) : rd_val) : $urandom;
  end

  initial forever begin
    @(negedge clk);
    if (bus.ms_to_ws_valid && bus.ws_allowin) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL wb_unexpected got=%h exp=none", bus.ms_to_ws_bus);
      else begin
        mon_exp = exp_q.pop_front();
        if (bus.ms_to_ws_bus !== mon_exp) $display("FAIL wb_bus got=%h exp=%h", bus.ms_to_ws_bus, mon_exp);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send(input logic [107:0] b, output logic acc_dok);
    int n;
    logic done;
    n = 0; done = 1'b0; acc_dok = 1'b0;
    bus.es_to_ms_valid = 1'b1; bus.es_to_ms_bus = b;
    while (!done && n < 50) begin
      @(negedge clk);
      if (bus.ms_allowin) begin done = 1'b1; acc_dok = bus.data_sram_data_ok; end
      @(posedge clk); #1;
      n++;
    end
    bus.es_to_ms_valid = 1'b0;
    checks++;
    if (!done) $display("FAIL send_timeout got=stalled exp=accepted"); else passed++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain got=%0d pending exp=0", exp_q.size()); else passed++;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.ms_to_ws_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.ms_to_ws_valid); else passed++;
    if (bus.data_sram_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bus.data_sram_req); else passed++;
    if (bus.ms_allowin !== 1'b1) $display("FAIL rst_allowin got=%b exp=1", bus.ms_allowin); else passed++;
    if (bus.ms_to_ds_bus !== 38'd0) $display("FAIL rst_ds_bus got=%h exp=0", bus.ms_to_ds_bus); else passed++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    logic dok, done, lp_ok;
    int occ;
    a_dly = 1; d_dly = 0; use_fn = 1'b0; rd_val = 32'h80FF_1234; bus.ws_allowin = 1'b1;
    exp_q.push_back(exp_wb(1'b1, 5'd3, 32'hFFFF_FF80, 32'h100));
    send(mk(1'b0, 2'd0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h1003, 32'h100), dok);
    occ = 0; done = 1'b0; lp_ok = 1'b1;
    while (!done && occ < 20) begin
      @(negedge clk);
      occ++;
      if (bus.ms_to_ws_valid) begin done = 1'b1; if (bus.ms_to_ds_bus[37] !== 1'b0) lp_ok = 1'b0; end
      else if (bus.ms_to_ds_bus[37] !== 1'b1) lp_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks += 2;
    if (occ != 3) $display("FAIL ldb_occupancy got=%0d exp=3", occ); else passed++;
    if (lp_ok !== 1'b1) $display("FAIL ldb_load_pending got=%b exp=1", lp_ok); else passed++;
    drain();
  endtask

  task automatic test_load_hold();
    logic dok, seen, hold_ok;
    int n;
    a_dly = 0; d_dly = 0; use_fn = 1'b0; rd_val = 32'h8001_0000; bus.ws_allowin = 1'b0;
    exp_q.push_back(exp_wb(1'b1, 5'd7, 32'h0000_8001, 32'h200));
    send(mk(1'b1, 2'd1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h2002, 32'h200), dok);
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (bus.data_sram_data_ok) seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    hold_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b0 || bus.ms_to_ds_bus !== {1'b0, 5'd7, 32'h0000_8001})
        hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks += 2;
    if (seen !== 1'b1) $display("FAIL ldhu_data_ok got=%b exp=1", seen); else passed++;
    if (hold_ok !== 1'b1) $display("FAIL ldhu_hold got=%h exp=%h", bus.ms_to_ds_bus, {1'b0, 5'd7, 32'h0000_8001}); else passed++;
    bus.ws_allowin = 1'b1;
    drain();
  endtask

  task automatic test_store();
    logic [1:0]  sz[4];
    logic [31:0] ad[4], sd[4], wd[4];
    logic [3:0]  sb[4];
    int          ad_dly[4];
    logic dok, got, f_ok;
    int n, reqc;
    sz = '{2'd0, 2'd1, 2'd2, 2'd0};
    ad = '{32'h3001, 32'h3002, 32'h3004, 32'h3003};
    sd = '{32'h0000_00AB, 32'h1234_CDEF, 32'h89AB_CDEF, 32'h0000_005A};
    wd = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h89AB_CDEF, 32'h5A5A_5A5A};
    sb = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
    ad_dly = '{4, 0, 1, 0};
    d_dly = 0; bus.ws_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_dly = ad_dly[i];
      exp_q.push_back(exp_wb(1'b0, 5'd0, ad[i], 32'h400 + i * 4));
      send(mk(1'b0, sz[i], 1'b1, 1'b1, 5'd0, sd[i], ad[i], 32'h400 + i * 4), dok);
      n = 0; reqc = 0; got = 1'b0; f_ok = 1'b1;
      while (!got && n < 20) begin
        @(negedge clk);
        if (bus.data_sram_req) begin
          reqc++;
          if (bus.data_sram_wr !== 1'b1 || bus.data_sram_wstrb !== sb[i] || bus.data_sram_wdata !== wd[i] ||
              bus.data_sram_addr !== ad[i] || bus.data_sram_size !== sz[i]) f_ok = 1'b0;
        end
        if (bus.data_sram_addr_ok) got = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      checks += 2;
      if (f_ok !== 1'b1) $display("FAIL st%0d_fields got=%b/%h exp=%b/%h", i, bus.data_sram_wstrb, bus.data_sram_wdata, sb[i], wd[i]);
      else passed++;
      if (reqc != ad_dly[i] + 1) $display("FAIL st%0d_req_cycles got=%0d exp=%0d", i, reqc, ad_dly[i] + 1); else passed++;
      drain();
    end
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz[8];
    logic        un[8];
    logic [31:0] ad[8], rd[8], ex[8];
    logic dok;
    sz = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
    un = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ad = '{32'h5000, 32'h5001, 32'h5000, 32'h5002, 32'h5002, 32'h5004, 32'h5000, 32'h5003};
    rd = '{32'h1122_3384, 32'h1122_F344, 32'h0000_8765, 32'h7ABC_0000,
           32'h00C5_0000, 32'hCAFE_BABE, 32'h0000_F00D, 32'h7F00_0000};
    ex = '{32'hFFFF_FF84, 32'h0000_00F3, 32'hFFFF_8765, 32'h0000_7ABC,
           32'h0000_00C5, 32'hCAFE_BABE, 32'h0000_F00D, 32'h0000_007F};
    use_fn = 1'b0; bus.ws_allowin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_dly = i % 2; d_dly = i % 3; rd_val = rd[i];
      exp_q.push_back(exp_wb(1'b1, 5'(i + 1), ex[i], 32'h500 + i * 4));
      send(mk(un[i], sz[i], 1'b0, 1'b1, 5'(i + 1), 32'h0, ad[i], 32'h500 + i * 4), dok);
      drain();
    end
  endtask

  task automatic test_back_to_back_add();
    logic dok;
    a_dly = 0; d_dly = 0; use_fn = 1'b0; rd_val = 32'h1234_5678; bus.ws_allowin = 1'b1;
    exp_q.push_back(exp_wb(1'b1, 5'd9, 32'h1234_5678, 32'h300));
    exp_q.push_back(exp_wb(1'b1, 5'd10, 32'hDEAD_BEEF, 32'h304));
    send(mk(1'b0, 2'd2, 1'b0, 1'b1, 5'd9, 32'h0, 32'h4000, 32'h300), dok);
    send(mk(1'b0, 2'd2, 1'b0, 1'b0, 5'd10, 32'h0, 32'hDEAD_BEEF, 32'h304), dok);
    @(negedge clk);
    checks += 2;
    if (dok !== 1'b1) $display("FAIL add_accept_on_data_ok got=%b exp=1", dok); else passed++;
    if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_to_ds_bus !== {1'b0, 5'd10, 32'hDEAD_BEEF})
      $display("FAIL add_issue got=%b/%h exp=1/%h", bus.ms_to_ws_valid, bus.ms_to_ds_bus, {1'b0, 5'd10, 32'hDEAD_BEEF});
    else passed++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    logic dok;
    int base;
    a_dly = 0; d_dly = 1; use_fn = 1'b1; bus.ws_allowin = 1'b1;
    base = n_req;
    exp_q.push_back(exp_wb(1'b1, 5'd11, mem_fn(32'h6000), 32'h600));
    exp_q.push_back(exp_wb(1'b1, 5'd12, mem_fn(32'h6010), 32'h604));
    send(mk(1'b0, 2'd2, 1'b0, 1'b1, 5'd11, 32'h0, 32'h6000, 32'h600), dok);
    send(mk(1'b0, 2'd2, 1'b0, 1'b1, 5'd12, 32'h0, 32'h6010, 32'h604), dok);
    @(negedge clk);
    checks += 2;
    if (dok !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", dok); else passed++;
    if (bus.data_sram_req !== 1'b1 || bus.data_sram_addr !== 32'h6010)
      $display("FAIL b2b_second_req got=%b/%h exp=1/00006010", bus.data_sram_req, bus.data_sram_addr);
    else passed++;
    @(posedge clk); #1;
    drain();
    checks++;
    if (n_req - base != 2) $display("FAIL b2b_req_count got=%0d exp=2", n_req - base); else passed++;
  endtask

  task automatic test_reset_mid();
    logic dok;
    a_dly = 0; d_dly = 50; use_fn = 1'b1; bus.ws_allowin = 1'b1;
    send(mk(1'b0, 2'd2, 1'b0, 1'b1, 5'd13, 32'h0, 32'h7000, 32'h700), dok);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.ms_to_ds_bus[37] !== 1'b1) $display("FAIL rm_in_wait got=%b exp=1", bus.ms_to_ds_bus[37]); else passed++;
    manual = 1'b1; man_dok = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checks += 3;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.data_sram_req !== 1'b0)
      $display("FAIL rm_async_clear got=%b/%b exp=0/0", bus.ms_to_ws_valid, bus.data_sram_req);
    else passed++;
    if (bus.ms_allowin !== 1'b1) $display("FAIL rm_async_allowin got=%b exp=1", bus.ms_allowin); else passed++;
    if (bus.ms_to_ds_bus !== 38'd0) $display("FAIL rm_async_ds got=%h exp=0", bus.ms_to_ds_bus); else passed++;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    man_dok = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1)
      $display("FAIL rm_stale_data_ok got=%b/%b exp=0/1", bus.ms_to_ws_valid, bus.ms_allowin);
    else passed++;
    if (bus.ms_to_ds_bus[37] !== 1'b0 || bus.data_sram_req !== 1'b0)
      $display("FAIL rm_stale_pending got=%b/%b exp=0/0", bus.ms_to_ds_bus[37], bus.data_sram_req);
    else passed++;
    man_dok = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.data_sram_req !== 1'b0)
      $display("FAIL rm_idle got=%b/%b exp=0/0", bus.ms_to_ws_valid, bus.data_sram_req);
    else passed++;
    @(posedge clk); #1;
    manual = 1'b0; d_dly = 0;
    exp_q.push_back(exp_wb(1'b1, 5'd14, mem_fn(32'h7100), 32'h710));
    send(mk(1'b0, 2'd2, 1'b0, 1'b1, 5'd14, 32'h0, 32'h7100, 32'h710), dok);
    drain();
  endtask

  initial begin
    bus.ws_allowin = 1'b1; bus.es_to_ms_valid = 1'b0; bus.es_to_ms_bus = '0;
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = '0;
    test_reset();
    test_load_byte();
    test_load_hold();
    test_store();
    test_load_ext();
    test_back_to_back_add();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue got=%0d exp=0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
